neuron_mode_arbiter: RTL and testbench
======================================

Name: neuron_mode_arbiter

Overview:
- Parametrised, registered successor to the combinational neuron-core mode mux.
- Selects one of NUM_MODES neuron cores (LIF, TD, FST, CONV, ...) and forwards its emit stream and its post-spike/learn-start pulses.
- Adds a valid/ready output register, per-core clock-enable gating, and a safe drain-and-quiet sequence on every mode change.
- Sits between the neuron cores and the output serialiser / learning FSM.

Parameters:
- NUM_MODES, 4, number of neuron cores (>=2).
- DATA_W, 8, emit data width.
- MODE_W, $clog2(NUM_MODES), width of mode fields.
- QUIET_CYCLES, 2, idle cycles with all cores disabled between drain and new-mode start (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- mode_req  in  MODE_W  requested mode; values >= NUM_MODES map to NUM_MODES-1.
- in_emit_valid  in  NUM_MODES  per-core emit valid.
- in_emit_data  in  NUM_MODES*DATA_W  per-core data; core i occupies bits [i*DATA_W +: DATA_W].
- in_emit_ready  out  NUM_MODES  per-core ready.
- in_post_spike  in  NUM_MODES  per-core post-spike pulse.
- in_learn_start  in  NUM_MODES  per-core learn-start pulse.
- core_enable  out  NUM_MODES  one-hot enable of the running core; all zero outside RUN.
- out_emit_valid  out  1  registered emit valid.
- out_emit_data  out  DATA_W  registered emit data.
- out_emit_ready  in  1  downstream ready.
- post_spike_pulse  out  1  registered post-spike pulse.
- learn_start_pulse  out  1  registered learn-start pulse.
- active_mode  out  MODE_W  mode currently running.
- switching  out  1  high in DRAIN or QUIET.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=QUIET, quiet counter=QUIET_CYCLES-1, target=0.
  - active_mode=0, core_enable=0.
  - out_emit_valid=0, out_emit_data=0, both pulses=0, switching=1.
  - in_emit_ready=0.
  - Reset mid-operation discards any held output word.
- Effective request: req_eff = (mode_req >= NUM_MODES) ? NUM_MODES-1 : mode_req.
- States:
  - RUN: core_enable=onehot(active_mode); switching=0.
    - in_emit_ready[active_mode] = !out_emit_valid || out_emit_ready; all other readies are 0.
    - Accept on in_emit_valid[active] && in_emit_ready[active]: out_emit_data <= that core's data and out_emit_valid <= 1 on the next edge. Latency is 1 cycle.
    - out_emit_valid clears on out_emit_ready with no new accept. Simultaneous pop and push keeps valid=1 with the new data, giving one word per cycle at full throughput.
    - Pulses: post_spike_pulse <= in_post_spike[active_mode] and learn_start_pulse <= in_learn_start[active_mode], one-cycle latency. All other cores' pulses are ignored.
    - If req_eff != active_mode: target <= req_eff, go to DRAIN. The transition cycle still accepts and forwards normally.
  - DRAIN: all in_emit_ready=0; core_enable stays asserted for active_mode so the core holds state; pulses still forwarded from active_mode.
    - If req_eff == active_mode: return to RUN (abort).
    - Else, when out_emit_valid==0 or (out_emit_valid && out_emit_ready): go to QUIET, counter=QUIET_CYCLES-1. target <= req_eff on this transition (the latest request wins).
  - QUIET: core_enable=0, all readies 0, pulse outputs 0, out_emit_valid=0.
    - Counter decrements each cycle. At 0: active_mode <= target, go to RUN.
    - mode_req changes during QUIET are not tracked; RUN re-evaluates them on its first cycle.
- After reset: the first RUN entry has active_mode=0. A nonzero mode_req then triggers a normal switch.
- No data loss: every word accepted in RUN is presented on out_emit_* until popped, including across a mode switch.
- core_enable is exactly one-hot in RUN/DRAIN and zero in QUIET; it never has two bits set in any cycle.

Decomposition:
- Shared package / neuron_defs.vh: NEURON_MODE_LIF=0, NEURON_MODE_TD=1, NEURON_MODE_FST=2, NEURON_MODE_CONV=3, and arbiter state encodings RUN/DRAIN/QUIET.
- Sub-module neuron_emit_reg: the 1-entry valid/ready output register (DATA_W parameter, push/pop/flush).
- Mux, FSM and pulse registers stay in neuron_mode_arbiter.

Test Plan:
- Reset release with mode_req=0 -> QUIET for 2 cycles, then RUN, core_enable=4'b0001, switching=0. All outputs are 0 until then.
- Mode 1, core 1 emits 0xA5 with out_emit_ready=1 -> out_emit_valid=1 and data 0xA5 one cycle later. in_emit_valid[2]=1 at the same time is never accepted (in_emit_ready[2]=0).
- Backpressure: out_emit_ready=0 with a word held -> in_emit_ready[active]=0 and data stable. Releasing ready with a new word pending gives back-to-back transfers with no bubble.
- Switch 0->3 with a held word 0x3C and out_emit_ready=0 for 5 cycles -> DRAIN holds until the pop, then 2 QUIET cycles with core_enable=0, then active_mode=3 and core_enable=4'b1000. 0x3C is delivered exactly once.
- In DRAIN, mode_req returns to the old mode -> back to RUN with no QUIET and core_enable never dropped. mode_req=7 with NUM_MODES=4 -> active_mode=3.
- Pulses: in_post_spike=4'b0110 with active=2 -> post_spike_pulse=1 one cycle later. learn_start on a non-active core -> 0. A pulse during QUIET -> dropped.

Source files
------------

// File: rtl/neuron_mode_arbiter_pkg.sv
// Shared neuron-core mode numbering and the arbiter's state encoding.
package neuron_mode_arbiter_pkg;

    localparam logic [1:0] NEURON_MODE_LIF  = 2'd0;
    localparam logic [1:0] NEURON_MODE_TD   = 2'd1;
    localparam logic [1:0] NEURON_MODE_FST  = 2'd2;
    localparam logic [1:0] NEURON_MODE_CONV = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_QUIET = 2'd2
    } arb_state_t;

endpackage

// File: rtl/neuron_emit_reg.sv
// One-entry valid/ready output register: 1-cycle latency, holds its word until popped.
// Push wins over pop in the same cycle so a full-rate stream sees no bubbles.
module neuron_emit_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_data  <= i_push_data;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/neuron_mode_arbiter.sv
// Selects one neuron core, registers its emit stream and pulses (1-cycle latency).
// Mode changes drain the held word, then idle all cores for QUIET_CYCLES before restart.
module neuron_mode_arbiter
    import neuron_mode_arbiter_pkg::*;
#(
    parameter int NUM_MODES    = 4,
    parameter int DATA_W       = 8,
    parameter int MODE_W       = $clog2(NUM_MODES),
    parameter int QUIET_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [MODE_W-1:0]           mode_req,
    input  logic [NUM_MODES-1:0]        in_emit_valid,
    input  logic [NUM_MODES*DATA_W-1:0] in_emit_data,
    output logic [NUM_MODES-1:0]        in_emit_ready,
    input  logic [NUM_MODES-1:0]        in_post_spike,
    input  logic [NUM_MODES-1:0]        in_learn_start,
    output logic [NUM_MODES-1:0]        core_enable,
    output logic                        out_emit_valid,
    output logic [DATA_W-1:0]           out_emit_data,
    input  logic                        out_emit_ready,
    output logic                        post_spike_pulse,
    output logic                        learn_start_pulse,
    output logic [MODE_W-1:0]           active_mode,
    output logic                        switching
);

    localparam int                QW            = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam logic [MODE_W-1:0] LP_MAX_MODE   = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W:0]   LP_NUM_MODES  = (MODE_W + 1)'(NUM_MODES);
    localparam logic [QW-1:0]     LP_QUIET_INIT = QW'(QUIET_CYCLES - 1);

    function automatic logic [NUM_MODES-1:0] f_onehot(input logic [MODE_W-1:0] m);
        f_onehot = NUM_MODES'(1) << m;
    endfunction

    arb_state_t           r_state;
    logic [QW-1:0]        r_cnt;
    logic [MODE_W-1:0]    r_target;
    logic [MODE_W-1:0]    r_active_mode;
    logic [NUM_MODES-1:0] r_core_enable;
    logic                 r_switching;
    logic                 r_post_spike;
    logic                 r_learn_start;

    logic [MODE_W-1:0]    w_req_eff;
    logic                 w_run;
    logic                 w_rdy;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_emit_vld;
    logic [DATA_W-1:0]    w_emit_dat;
    logic [DATA_W-1:0]    w_sel_data;

    // Out-of-range requests fold onto the highest-numbered core.
    assign w_req_eff  = ({1'b0, mode_req} >= LP_NUM_MODES) ? LP_MAX_MODE : mode_req;
    assign w_run      = (r_state == ST_RUN);
    assign w_rdy      = w_run && (!w_emit_vld || out_emit_ready);
    assign w_push     = w_rdy && in_emit_valid[r_active_mode];
    assign w_pop      = w_emit_vld && out_emit_ready;
    assign w_sel_data = in_emit_data[int'(r_active_mode)*DATA_W +: DATA_W];

    neuron_emit_reg #(
        .DATA_W (DATA_W)
    ) u_emit_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_sel_data),
        .i_pop       (w_pop),
        .i_flush     (r_state == ST_QUIET),
        .o_valid     (w_emit_vld),
        .o_data      (w_emit_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_QUIET;
            r_cnt         <= LP_QUIET_INIT;
            r_target      <= '0;
            r_active_mode <= MODE_W'(NEURON_MODE_LIF);
            r_core_enable <= '0;
            r_switching   <= 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_req_eff != r_active_mode) begin
                        r_target    <= w_req_eff;
                        r_state     <= ST_DRAIN;
                        r_switching <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The core stays enabled while draining so an abort resumes it intact.
                    if (w_req_eff == r_active_mode) begin
                        r_state     <= ST_RUN;
                        r_switching <= 1'b0;
                    end else if (!w_emit_vld || out_emit_ready) begin
                        r_state       <= ST_QUIET;
                        r_cnt         <= LP_QUIET_INIT;
                        r_target      <= w_req_eff;
                        r_core_enable <= '0;
                    end
                end
                ST_QUIET: begin
                    if (r_cnt == '0) begin
                        r_active_mode <= r_target;
                        r_state       <= ST_RUN;
                        r_core_enable <= f_onehot(r_target);
                        r_switching   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - QW'(1);
                    end
                end
                default: begin
                    r_state       <= ST_QUIET;
                    r_cnt         <= LP_QUIET_INIT;
                    r_core_enable <= '0;
                    r_switching   <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || r_state == ST_QUIET) begin
            r_post_spike  <= 1'b0;
            r_learn_start <= 1'b0;
        end else begin
            r_post_spike  <= in_post_spike[r_active_mode];
            r_learn_start <= in_learn_start[r_active_mode];
        end
    end

    assign in_emit_ready     = w_rdy ? f_onehot(r_active_mode) : '0;
    assign core_enable       = r_core_enable;
    assign out_emit_valid    = w_emit_vld;
    assign out_emit_data     = w_emit_dat;
    assign post_spike_pulse  = r_post_spike;
    assign learn_start_pulse = r_learn_start;
    assign active_mode       = r_active_mode;
    assign switching         = r_switching;

endmodule

// File: tb/tb_neuron_mode_arbiter.sv
// Bench for neuron_mode_arbiter: directed vector table, corner sequences, random traffic vs a queue model.
module tb_neuron_mode_arbiter;
    import neuron_mode_arbiter_pkg::*;

    localparam int NM = 4;
    localparam int DW = 8;
    localparam int MW = 2;
    localparam int QC = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [MW-1:0]    mode_req;
    logic [NM-1:0]    in_emit_valid;
    logic [NM*DW-1:0] in_emit_data;
    logic [NM-1:0]    in_emit_ready;
    logic [NM-1:0]    in_post_spike;
    logic [NM-1:0]    in_learn_start;
    logic [NM-1:0]    core_enable;
    logic             out_emit_valid;
    logic [DW-1:0]    out_emit_data;
    logic             out_emit_ready;
    logic             post_spike_pulse;
    logic             learn_start_pulse;
    logic [MW-1:0]    active_mode;
    logic             switching;

    neuron_mode_arbiter #(
        .NUM_MODES    (NM),
        .DATA_W       (DW),
        .MODE_W       (MW),
        .QUIET_CYCLES (QC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mode_req          (mode_req),
        .in_emit_valid     (in_emit_valid),
        .in_emit_data      (in_emit_data),
        .in_emit_ready     (in_emit_ready),
        .in_post_spike     (in_post_spike),
        .in_learn_start    (in_learn_start),
        .core_enable       (core_enable),
        .out_emit_valid    (out_emit_valid),
        .out_emit_data     (out_emit_data),
        .out_emit_ready    (out_emit_ready),
        .post_spike_pulse  (post_spike_pulse),
        .learn_start_pulse (learn_start_pulse),
        .active_mode       (active_mode),
        .switching         (switching)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: pending words as a queue, phases as "quiet cycles left" and a draining flag.
    logic [DW-1:0] m_q[$];
    int  m_quiet, m_active, m_target;
    bit  m_drain, m_ps, m_ls;
    int  accepted = 0, delivered = 0, discarded = 0, n3c = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NM-1:0] oh(input int i);
        logic [NM-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        discarded += m_q.size();
        m_q.delete();
        m_quiet = QC; m_drain = 0; m_active = 0; m_target = 0; m_ps = 0; m_ls = 0;
    endtask

    task automatic tick();
        logic [NM-1:0] e_rdy;
        bit run, pop, push;
        int req;
        #1;
        run = (m_quiet == 0) && !m_drain;
        if (rst_n) begin
            e_rdy = (run && (m_q.size() == 0 || out_emit_ready)) ? oh(m_active) : '0;
            chk("in_emit_ready", 32'(in_emit_ready), 32'(e_rdy));
            if (out_emit_valid && out_emit_ready) begin
                delivered++;
                if (out_emit_data == 8'h3C) n3c++;
            end
        end
        if (!rst_n) begin
            model_reset();
        end else begin
            pop  = (m_q.size() > 0) && out_emit_ready;
            push = run && (m_q.size() == 0 || out_emit_ready) && in_emit_valid[m_active];
            m_ps = (m_quiet == 0) ? in_post_spike[m_active]  : 1'b0;
            m_ls = (m_quiet == 0) ? in_learn_start[m_active] : 1'b0;
            req  = (int'(mode_req) >= NM) ? NM - 1 : int'(mode_req);
            if (m_quiet > 0) begin
                m_quiet--;
                if (m_quiet == 0) m_active = m_target;
            end else if (m_drain) begin
                if (req == m_active) m_drain = 0;
                else if (m_q.size() == 0 || pop) begin
                    m_drain = 0; m_quiet = QC; m_target = req;
                end
            end else if (req != m_active) begin
                m_drain = 1;
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back(in_emit_data[m_active*DW +: DW]);
                accepted++;
            end
        end
        @(posedge clk);
        #1;
        chk("core_enable", 32'(core_enable), 32'((m_quiet > 0) ? '0 : oh(m_active)));
        chk("switching", 32'(switching), 32'(m_quiet > 0 || m_drain));
        chk("out_emit_valid", 32'(out_emit_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("out_emit_data", 32'(out_emit_data), 32'(m_q[0]));
        chk("active_mode", 32'(active_mode), 32'(m_active));
        chk("post_spike_pulse", 32'(post_spike_pulse), 32'(m_ps));
        chk("learn_start_pulse", 32'(learn_start_pulse), 32'(m_ls));
    endtask

    typedef struct {
        logic [MW-1:0]    mode;
        logic [NM-1:0]    vld;
        logic [NM*DW-1:0] dat;
        logic             ordy;
        logic [NM-1:0]    ps;
        logic [NM-1:0]    ls;
        logic [NM-1:0]    e_en;
        logic             e_sw;
        logic             e_vld;
        logic [DW-1:0]    e_dat;
        logic [MW-1:0]    e_act;
        logic             e_ps;
        logic             e_ls;
    } vec_t;

    vec_t tbl[15];

    task automatic set_idle();
        in_emit_valid = '0; in_emit_data = '0; in_post_spike = '0; in_learn_start = '0;
    endtask

    initial begin
        tbl[0]  = '{2'd0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{2'd0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{2'd0, 4'b0001, 32'h00000011, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 8'h11, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{2'd1, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{2'd1, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{2'd1, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{2'd1, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0};
        tbl[7]  = '{2'd1, 4'b0110, 32'h005AA500, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 8'hA5, 2'd1, 1'b0, 1'b0};
        tbl[8]  = '{2'd1, 4'b0110, 32'h005AB600, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 8'hA5, 2'd1, 1'b0, 1'b0};
        tbl[9]  = '{2'd1, 4'b0110, 32'h005AB600, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 8'hA5, 2'd1, 1'b0, 1'b0};
        tbl[10] = '{2'd1, 4'b0010, 32'h0000B600, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 8'hB6, 2'd1, 1'b0, 1'b0};
        tbl[11] = '{2'd1, 4'b0010, 32'h0000C700, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 8'hC7, 2'd1, 1'b0, 1'b0};
        tbl[12] = '{2'd1, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0};
        tbl[13] = '{2'd1, 4'b0000, 32'h00000000, 1'b1, 4'b1101, 4'b0010, 4'b0010, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 1'b1};
        tbl[14] = '{2'd1, 4'b0000, 32'h00000000, 1'b1, 4'b0010, 4'b1101, 4'b0010, 1'b0, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0};

        rst_n = 1'b0; mode_req = '0; out_emit_ready = 1'b1;
        set_idle();
        model_reset();
        tick();
        tick();
        chk("rst_core_enable", 32'(core_enable), 32'h0);
        chk("rst_switching", 32'(switching), 32'h1);
        chk("rst_out_valid", 32'(out_emit_valid), 32'h0);
        chk("rst_out_data", 32'(out_emit_data), 32'h0);
        chk("rst_pulses", 32'({post_spike_pulse, learn_start_pulse}), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            mode_req = tbl[i].mode; in_emit_valid = tbl[i].vld; in_emit_data = tbl[i].dat;
            out_emit_ready = tbl[i].ordy; in_post_spike = tbl[i].ps; in_learn_start = tbl[i].ls;
            tick();
            chk($sformatf("tbl%0d_en", i), 32'(core_enable), 32'(tbl[i].e_en));
            chk($sformatf("tbl%0d_sw", i), 32'(switching), 32'(tbl[i].e_sw));
            chk($sformatf("tbl%0d_vld", i), 32'(out_emit_valid), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) chk($sformatf("tbl%0d_dat", i), 32'(out_emit_data), 32'(tbl[i].e_dat));
            chk($sformatf("tbl%0d_act", i), 32'(active_mode), 32'(tbl[i].e_act));
            chk($sformatf("tbl%0d_ps", i), 32'(post_spike_pulse), 32'(tbl[i].e_ps));
            chk($sformatf("tbl%0d_ls", i), 32'(learn_start_pulse), 32'(tbl[i].e_ls));
        end
        set_idle();

        // Held word discarded by a mid-operation reset.
        in_emit_valid = 4'b0010; in_emit_data = 32'h00009900; out_emit_ready = 1'b0;
        tick();
        chk("held_before_rst", 32'(out_emit_valid), 32'h1);
        set_idle(); rst_n = 1'b0; mode_req = 2'(NEURON_MODE_LIF);
        tick();
        chk("rst_mid_valid", 32'(out_emit_valid), 32'h0);
        chk("rst_mid_data", 32'(out_emit_data), 32'h0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rerun_en", 32'(core_enable), 32'h1);

        // Switch 0 -> 3 (requested as 7) with a held 0x3C under 5 cycles of backpressure.
        n3c = 0;
        in_emit_valid = 4'b0001; in_emit_data = 32'h0000003C;
        tick();
        set_idle(); mode_req = MW'(7);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("drain_sw", 32'(switching), 32'h1);
            chk("drain_hold", 32'({out_emit_valid, out_emit_data}), 32'h13C);
            chk("drain_en", 32'(core_enable), 32'h1);
        end
        out_emit_ready = 1'b1;
        tick();
        chk("quiet1_en", 32'(core_enable), 32'h0);
        tick();
        chk("quiet2_en", 32'(core_enable), 32'h0);
        tick();
        chk("sw3_act", 32'(active_mode), 32'(NEURON_MODE_CONV));
        chk("sw3_en", 32'(core_enable), 32'h8);
        chk("3c_once", 32'(n3c), 32'h1);

        // Abort: request goes back to the running mode while draining.
        mode_req = 2'd3; out_emit_ready = 1'b0;
        in_emit_valid = 4'b1000; in_emit_data = 32'h77000000;
        tick();
        set_idle(); mode_req = 2'(NEURON_MODE_LIF);
        tick();
        chk("abort_drain_en", 32'(core_enable), 32'h8);
        tick();
        chk("abort_drain_en2", 32'(core_enable), 32'h8);
        mode_req = 2'd3;
        tick();
        chk("abort_run_sw", 32'(switching), 32'h0);
        chk("abort_run_en", 32'(core_enable), 32'h8);
        out_emit_ready = 1'b1;
        tick();

        // Pulses: dropped in QUIET, forwarded only from the active core.
        mode_req = 2'(NEURON_MODE_FST);
        tick();
        tick();
        in_post_spike = 4'b1111; in_learn_start = 4'b1111;
        tick();
        chk("quiet_ps_drop", 32'({post_spike_pulse, learn_start_pulse}), 32'h0);
        set_idle();
        tick();
        chk("fst_act", 32'(active_mode), 32'h2);
        in_post_spike = 4'b0110; in_learn_start = 4'b1011;
        tick();
        chk("ps_active2", 32'(post_spike_pulse), 32'h1);
        chk("ls_inactive", 32'(learn_start_pulse), 32'h0);
        set_idle();
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 19) == 0) mode_req = MW'($urandom_range(0, 3));
            in_emit_valid  = NM'($urandom);
            in_emit_data   = $urandom;
            in_post_spike  = NM'($urandom);
            in_learn_start = NM'($urandom);
            out_emit_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst_n = 1'b1; set_idle(); out_emit_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        chk("word_conservation", 32'(accepted), 32'(delivered + discarded));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
